// File: rtl/pri_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pri_pkg
//  Purpose  : Shared widths and types for the priority-normalizer datapath.
//  Revision : 1.0  initial release
// ============================================================================
package pri_pkg;

   localparam int WIDTH     = 56;   // data width and number of legal MSB slots
   localparam int WIDTH_LOG = 6;    // index / shift width
   localparam int SPLIT     = 3;    // low shift bits deferred to stage 2

   typedef logic [WIDTH-1:0]     pri_word_t;
   typedef logic [WIDTH_LOG-1:0] pri_idx_t;

endpackage
`default_nettype wire

// File: rtl/pri_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pri_shift_stage
//  Purpose  : Registered barrel-shift slice with valid/ready. Applies the
//             shift bits at or above LSB, forwards the bits below LSB as the
//             remaining shift, and carries total shift and flags alongside.
//  Revision : 1.0  initial release
// ============================================================================
module pri_shift_stage #(
   parameter int WIDTH = 56,
   parameter int SHW   = 6,
   parameter int LSB   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_rem,
   input  logic [SHW-1:0]   in_tot,
   input  logic             in_zero,
   input  logic             in_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SHW-1:0]   out_rem,
   output logic [SHW-1:0]   out_tot,
   output logic             out_zero,
   output logic             out_err
);

   // Shift bits below LSB are left for a later slice.
   localparam logic [SHW-1:0] c_LOW_MASK = SHW'((1 << LSB) - 1);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d,  data_q;
   logic [SHW-1:0]   rem_d,   rem_q;
   logic [SHW-1:0]   tot_d,   tot_q;
   logic             zero_d,  zero_q;
   logic             err_d,   err_q;

   // Register may load when empty or when its content leaves this cycle.
   assign in_ready = !valid_q || out_ready;

   // Next-state: payload only changes on an accepted word, so it holds under stall.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      rem_d   = rem_q;
      tot_d   = tot_q;
      zero_d  = zero_q;
      err_d   = err_q;
      if (in_ready) begin
         valid_d = in_valid;
      end
      if (in_ready && in_valid) begin
         data_d = in_data << (in_rem & ~c_LOW_MASK);
         rem_d  = in_rem & c_LOW_MASK;
         tot_d  = in_tot;
         zero_d = in_zero;
         err_d  = in_err;
      end
   end

   // State registers with synchronous clear; reset discards any word held.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         rem_q   <= '0;
         tot_q   <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         tot_q   <= tot_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_rem   = rem_q;
   assign out_tot   = tot_q;
   assign out_zero  = zero_q;
   assign out_err   = err_q;

endmodule
`default_nettype wire

// File: rtl/pri_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : pri_normalizer
//  Purpose  : Left-normalizes a word so its leading one sits at the top bit,
//             using the upstream encoder's MSB index, and flags any index
//             that disagrees with the data. Two-stage valid/ready pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module pri_normalizer
   import pri_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      in_valid,
   output logic      in_ready,
   input  pri_word_t in_data,
   input  pri_idx_t  in_msb,
   output logic      out_valid,
   input  logic      out_ready,
   output pri_word_t out_data,
   output pri_idx_t  out_shift,
   output logic      out_zero,
   output logic      out_err
);

   logic      w_zero;
   logic      w_err;
   pri_word_t w_hi;
   pri_idx_t  w_sh;

   logic      w_s1_valid, w_s2_ready;
   pri_word_t w_s1_data;
   pri_idx_t  w_s1_rem, w_s1_tot;
   logic      w_s1_zero, w_s1_err;
   pri_idx_t  w_s2_rem, w_s2_tot;

   // Encoder check: data shifted down by the claimed index must be exactly 1;
   // out-of-range indices shift everything out and fail the same test.
   always_comb begin
      w_zero = ~|in_data;
      w_hi   = in_data >> in_msb;
      w_err  = w_zero ? (in_msb != '0) : (w_hi != pri_word_t'(1));
      w_sh   = (w_zero || w_err) ? '0 : (pri_idx_t'(WIDTH - 1) - in_msb);
   end

   pri_shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (WIDTH_LOG),
      .LSB   (SPLIT)
   ) u_stage1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_rem    (w_sh),
      .in_tot    (w_sh),
      .in_zero   (w_zero),
      .in_err    (w_err),
      .out_valid (w_s1_valid),
      .out_ready (w_s2_ready),
      .out_data  (w_s1_data),
      .out_rem   (w_s1_rem),
      .out_tot   (w_s1_tot),
      .out_zero  (w_s1_zero),
      .out_err   (w_s1_err)
   );

   pri_shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (WIDTH_LOG),
      .LSB   (0)
   ) u_stage2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_s1_valid),
      .in_ready  (w_s2_ready),
      .in_data   (w_s1_data),
      .in_rem    (w_s1_rem),
      .in_tot    (w_s1_tot),
      .in_zero   (w_s1_zero),
      .in_err    (w_s1_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rem   (w_s2_rem),
      .out_tot   (w_s2_tot),
      .out_zero  (out_zero),
      .out_err   (out_err)
   );

   // The final slice consumes every remaining bit, so its remainder is zero.
   assign out_shift = w_s2_tot | w_s2_rem;

endmodule
`default_nettype wire

// File: tb/tb_pri_normalizer.sv
`timescale 1ns/1ps
module tb_pri_normalizer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [55:0] in_data;
   logic [5:0]  in_msb;
   logic        out_valid;
   logic        out_ready;
   logic [55:0] out_data;
   logic [5:0]  out_shift;
   logic        out_zero;
   logic        out_err;

   typedef struct {
      logic [55:0] d;
      logic [5:0]  s;
      logic        z;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   int   out_cyc[$];
   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;
   int   cyc    = 0;
   bit   stall_seen = 0;
   bit   bp_done    = 0;

   pri_normalizer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_msb    (in_msb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_shift (out_shift),
      .out_zero  (out_zero),
      .out_err   (out_err)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: scan for the true leading one, then apply the rules directly.
   function automatic exp_t model(input logic [55:0] d, input logic [5:0] m);
      exp_t r;
      int   tm = -1;
      for (int i = 0; i < 56; i++) if (d[i]) tm = i;
      r.z = (d == 56'd0);
      r.e = r.z ? (m != 6'd0) : (int'(m) != tm);
      r.s = (r.z || r.e) ? 6'd0 : 6'(55 - int'(m));
      r.d = d << r.s;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Output monitor: every consumed word must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'(out_data), 64'hDEAD);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_data",  64'(out_data),  64'(e.d));
            chk("out_shift", 64'(out_shift), 64'(e.s));
            chk("out_zero",  64'(out_zero),  64'(e.z));
            chk("out_err",   64'(out_err),   64'(e.e));
         end
         out_cyc.push_back(cyc);
      end
   end

   task automatic send(input logic [55:0] d, input logic [5:0] m);
      int n   = 0;
      bit got = 0;
      in_valid = 1;
      in_data  = d;
      in_msb   = m;
      while (!got) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(d, m));
            got = 1;
         end else begin
            stall_seen = 1;
            n++;
            if (n > 200) begin
               checks++;
               fails++;
               $error("FAIL send_timeout: observed in_ready 0 expected 1");
               got = 1;
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [55:0] ones;
      int          idx0;
      int          nout;
      ones      = '1;
      rst       = 1;
      in_valid  = 0;
      in_data   = '0;
      in_msb    = '0;
      out_ready = 1;

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_shift", 64'(out_shift), 64'd0);
      chk("rst_out_zero",  64'(out_zero),  64'd0);
      chk("rst_out_err",   64'(out_err),   64'd0);
      @(posedge clk);
      #1;

      // Single word with the leading one at bit 0
      send(56'h1, 6'd0);
      drain();

      // Encoder sweep, back to back
      idx0       = out_cyc.size();
      stall_seen = 0;
      for (int k = 0; k <= 54; k++) send(ones >> (k + 1), 6'(54 - k));
      drain();
      chk("sweep_count", 64'(out_cyc.size() - idx0), 64'd55);
      if (out_cyc.size() - idx0 == 55)
         chk("sweep_consecutive", 64'(out_cyc[idx0 + 54] - out_cyc[idx0]), 64'd54);
      chk("sweep_no_stall", 64'(stall_seen), 64'd0);

      // Zero word and inconsistent indices
      send(56'h0, 6'd0);
      send(56'h0, 6'd5);
      send(56'h80, 6'd6);
      send(56'h80, 6'd60);
      send(56'h80, 6'd7);
      drain();

      // Back-pressure: out_ready 1,0,0,1,0,0,...
      stall_seen = 0;
      bp_done    = 0;
      nout       = out_cyc.size();
      fork
         begin
            for (int i = 0; i < 8; i++) send(56'h1 << (i * 5 + 3), 6'(i * 5 + 3));
            bp_done = 1;
         end
         begin
            int ph = 0;
            while (!bp_done) begin
               out_ready = (ph % 3 == 0);
               ph++;
               @(posedge clk);
               #1;
            end
         end
      join
      out_ready = 1;
      drain();
      chk("bp_stall_seen", 64'(stall_seen), 64'd1);
      chk("bp_count", 64'(out_cyc.size() - nout), 64'd8);

      // Reset with two words in flight
      out_ready = 0;
      send(56'h3, 6'd1);
      send(56'h4, 6'd2);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      exp_q.delete();
      nout      = out_cyc.size();
      out_ready = 1;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_no_output", 64'(out_cyc.size() - nout), 64'd0);

      // Randomized traffic with random back-pressure
      bp_done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [63:0] t;
               logic [55:0] d;
               logic [5:0]  m;
               int          r;
               int          k;
               t = {$urandom, $urandom};
               r = int'($urandom_range(0, 9));
               k = int'($urandom_range(0, 55));
               if (r == 0) begin
                  d = '0;
                  m = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
               end else begin
                  d = 56'((t & ((64'd1 << k) - 64'd1)) | (64'd1 << k));
                  m = (r == 1) ? 6'($urandom_range(0, 63)) : 6'(k);
               end
               send(d, m);
            end
            bp_done = 1;
         end
         begin
            while (!bp_done) begin
               out_ready = ($urandom_range(0, 9) < 7);
               @(posedge clk);
               #1;
            end
         end
      join
      out_ready = 1;
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
